io_input_cond: RTL and testbench

- Input-conditioning stage directly upstream of the singlecycle core's i_io_sw / i_io_btn ports.
- Synchronises the asynchronous board switches, and synchronises plus debounces the push-buttons.
- Normalises button polarity to active-high and produces one-cycle press/release/change pulses for later IRQ or peripheral use.
- Top level instantiates it between the board pins and the core.

---
 rtl/io_input_cond.sv | 201 ++++++++++++++++++++
 tb/tb_io_input_cond.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/io_input_cond.sv
// Board input conditioning: 2-flop switch synchroniser with change pulse, and per-button
// synchroniser + debounce FSM with press/release pulses. Optional IO_BTN_STICKY_EN adds sticky bits.
module io_input_cond #(
  parameter int unsigned SW_W           = 32,
  parameter int unsigned BTN_W          = 4,
  parameter int unsigned DB_CYCLES      = 500000,
  parameter bit          BTN_ACTIVE_LOW = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [SW_W-1:0]  i_sw_raw,
  input  logic [BTN_W-1:0] i_btn_raw,
`ifdef IO_BTN_STICKY_EN
  input  logic [BTN_W-1:0] i_btn_clr,
  output logic [BTN_W-1:0] o_btn_sticky,
`endif
  output logic [SW_W-1:0]  o_io_sw,
  output logic [BTN_W-1:0] o_io_btn,
  output logic [BTN_W-1:0] o_btn_press,
  output logic [BTN_W-1:0] o_btn_release,
  output logic             o_sw_change
);

  localparam int unsigned CntW = $clog2(DB_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DB_CYCLES - 1);
  localparam logic [CntW-1:0] CntMax  = {CntW{1'b1}};
  // Synchroniser reset level matches a released button so reset never looks like a press.
  localparam logic [BTN_W-1:0] BtnIdle = {BTN_W{BTN_ACTIVE_LOW}};

  typedef enum logic [1:0] {
    StRel,
    StChkP,
    StPrs,
    StChkR
  } btn_st_e;

  // ---------------------------------------------------------------------------
  // Switch path
  // ---------------------------------------------------------------------------
  logic [SW_W-1:0] sw_meta_q, sw_meta_d;
  logic [SW_W-1:0] sw_sync_q, sw_sync_d;
  logic [SW_W-1:0] sw_prev_q, sw_prev_d;
  logic            sw_chg_q, sw_chg_d;

  always_comb begin
    sw_meta_d = i_sw_raw;
    sw_sync_d = sw_meta_q;
    sw_prev_d = sw_sync_q;
    sw_chg_d  = (sw_sync_q != sw_prev_q);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      sw_prev_q <= '0;
      sw_chg_q  <= 1'b0;
    end else begin
      sw_meta_q <= sw_meta_d;
      sw_sync_q <= sw_sync_d;
      sw_prev_q <= sw_prev_d;
      sw_chg_q  <= sw_chg_d;
    end
  end

  assign o_io_sw     = sw_sync_q;
  assign o_sw_change = sw_chg_q;

  // ---------------------------------------------------------------------------
  // Button synchroniser and polarity normalisation
  // ---------------------------------------------------------------------------
  logic [BTN_W-1:0] btn_meta_q, btn_meta_d;
  logic [BTN_W-1:0] btn_sync_q, btn_sync_d;
  logic [BTN_W-1:0] btn_p;

  always_comb begin
    btn_meta_d = i_btn_raw;
    btn_sync_d = btn_meta_q;
    btn_p      = btn_sync_q ^ BtnIdle;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      btn_meta_q <= BtnIdle;
      btn_sync_q <= BtnIdle;
    end else begin
      btn_meta_q <= btn_meta_d;
      btn_sync_q <= btn_sync_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-button debounce FSM
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < BTN_W; gi++) begin : g_btn
    btn_st_e         st_q, st_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            lvl_q, lvl_d;
    logic            prs_q, prs_d;
    logic            rel_q, rel_d;
    logic            cnt_last;
    logic [CntW-1:0] cnt_inc;

    always_comb begin
      cnt_last = (cnt_q == CntLast);
      cnt_inc  = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
    end

    // The state must hold for DB_CYCLES consecutive samples in CHK_* before acceptance.
    always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      lvl_d = lvl_q;
      prs_d = 1'b0;
      rel_d = 1'b0;
      unique case (st_q)
        StRel: begin
          if (btn_p[gi]) begin
            st_d  = StChkP;
            cnt_d = '0;
          end
        end
        StChkP: begin
          if (!btn_p[gi]) begin
            st_d = StRel;
          end else if (cnt_last) begin
            st_d  = StPrs;
            lvl_d = 1'b1;
            prs_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        StPrs: begin
          if (!btn_p[gi]) begin
            st_d  = StChkR;
            cnt_d = '0;
          end
        end
        StChkR: begin
          if (btn_p[gi]) begin
            st_d = StPrs;
          end else if (cnt_last) begin
            st_d  = StRel;
            lvl_d = 1'b0;
            rel_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          st_d  = StRel;
          cnt_d = '0;
          lvl_d = 1'b0;
        end
      endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        st_q  <= StRel;
        cnt_q <= '0;
        lvl_q <= 1'b0;
        prs_q <= 1'b0;
        rel_q <= 1'b0;
      end else begin
        st_q  <= st_d;
        cnt_q <= cnt_d;
        lvl_q <= lvl_d;
        prs_q <= prs_d;
        rel_q <= rel_d;
      end
    end

    assign o_io_btn[gi]      = lvl_q;
    assign o_btn_press[gi]   = prs_q;
    assign o_btn_release[gi] = rel_q;
  end

`ifdef IO_BTN_STICKY_EN
  // ---------------------------------------------------------------------------
  // Sticky press flags, write-1-to-clear; a press in the clear cycle wins
  // ---------------------------------------------------------------------------
  logic [BTN_W-1:0] sticky_q, sticky_d;

  always_comb begin
    sticky_d = o_btn_press | (sticky_q & ~i_btn_clr);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign o_btn_sticky = sticky_q;
`endif

endmodule

// File: tb/tb_io_input_cond.sv
// Directed bench for io_input_cond with DB_CYCLES=4, active-low buttons.
module tb_io_input_cond;

  logic        clk;
  logic        rst_n;
  logic [31:0] sw_raw;
  logic [3:0]  btn_raw;
  logic [31:0] io_sw;
  logic [3:0]  io_btn;
  logic [3:0]  btn_press;
  logic [3:0]  btn_release;
  logic        sw_change;
`ifdef IO_BTN_STICKY_EN
  logic [3:0]  btn_clr;
  logic [3:0]  btn_sticky;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [3:0] press_or;
  logic [3:0] rel_or;
  int         press1_cnt;
  logic       lvl0_and;

  io_input_cond #(
    .SW_W          (32),
    .BTN_W         (4),
    .DB_CYCLES     (4),
    .BTN_ACTIVE_LOW(1'b1)
  ) u_dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_sw_raw     (sw_raw),
    .i_btn_raw    (btn_raw),
`ifdef IO_BTN_STICKY_EN
    .i_btn_clr    (btn_clr),
    .o_btn_sticky (btn_sticky),
`endif
    .o_io_sw      (io_sw),
    .o_io_btn     (io_btn),
    .o_btn_press  (btn_press),
    .o_btn_release(btn_release),
    .o_sw_change  (sw_change)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One rising edge, then settle; accumulates pulse observations.
  task automatic tick();
    @(posedge clk);
    #1;
    press_or = press_or | btn_press;
    rel_or   = rel_or | btn_release;
    if (btn_press[1]) press1_cnt++;
    lvl0_and = lvl0_and & io_btn[0];
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    sw_raw     = 32'h0;
    btn_raw    = 4'hF;
    press_or   = 4'h0;
    rel_or     = 4'h0;
    press1_cnt = 0;
    lvl0_and   = 1'b1;
`ifdef IO_BTN_STICKY_EN
    btn_clr    = 4'h0;
`endif
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_sw", io_sw, 32'h0);
    check("rst_btn", 32'(io_btn), 32'h0);
    check("rst_press", 32'(btn_press), 32'h0);
    check("rst_release", 32'(btn_release), 32'h0);
    check("rst_chg", 32'(sw_change), 32'h0);
`ifdef IO_BTN_STICKY_EN
    check("rst_sticky", 32'(btn_sticky), 32'h0);
`endif
    rst_n = 1'b1;
    ticks(4);
    check("post_rst_pulses", 32'({press_or, rel_or, 3'b000, sw_change}), 32'h0);

    // Switch path: 2-edge latency, change pulse on edge 3 only.
    sw_raw = 32'hDEADBEEF;
    tick();
    check("sw_lat1", io_sw, 32'h0);
    tick();
    check("sw_lat2", io_sw, 32'hDEADBEEF);
    check("sw_chg_e2", 32'(sw_change), 32'h0);
    tick();
    check("sw_chg_e3", 32'(sw_change), 32'h1);
    tick();
    check("sw_chg_e4", 32'(sw_change), 32'h0);

    // Clean press of button 0: accepted on edge 7.
    press_or = 4'h0;
    btn_raw  = 4'b1110;
    ticks(6);
    check("btn0_e6", 32'(io_btn), 32'h0);
    tick();
    check("btn0_e7_lvl", 32'(io_btn), 32'h1);
    check("btn0_e7_press", 32'(btn_press), 32'h1);
    tick();
    check("btn0_e8_press", 32'(btn_press), 32'h0);
    check("btn0_e8_lvl", 32'(io_btn), 32'h1);
    check("btn0_only", 32'(press_or), 32'h1);

    // One-cycle release glitch while held.
    rel_or   = 4'h0;
    lvl0_and = 1'b1;
    btn_raw  = 4'b1111;
    tick();
    btn_raw  = 4'b1110;
    ticks(10);
    check("glitch_no_rel", 32'(rel_or), 32'h0);
    check("glitch_lvl", 32'(lvl0_and), 32'h1);

    // Bounce on button 1, then stable press.
    press1_cnt = 0;
    btn_raw = 4'b1100; ticks(2);
    btn_raw = 4'b1110; ticks(2);
    btn_raw = 4'b1100; ticks(2);
    btn_raw = 4'b1110; ticks(2);
    btn_raw = 4'b1100;
    ticks(6);
    check("bounce_e6", 32'(io_btn), 32'h1);
    tick();
    check("bounce_e7_press", 32'(btn_press), 32'h2);
    tick();
    check("bounce_one_pulse", 32'(press1_cnt), 32'h1);

    // Buttons 2 and 3 together.
    btn_raw = 4'b0000;
    ticks(6);
    check("dual_e6", 32'(btn_press), 32'h0);
    tick();
    check("dual_e7_press", 32'(btn_press), 32'hC);
    check("dual_e7_lvl", 32'(io_btn), 32'hF);

    // Release all.
    btn_raw = 4'b1111;
    ticks(7);
    check("rel_all", 32'(btn_release), 32'hF);
    check("rel_all_lvl", 32'(io_btn), 32'h0);

    // Button 3 press alongside a switch change.
    btn_raw = 4'b0111;
    sw_raw  = 32'h0;
    ticks(3);
    check("sw_chg2", 32'(sw_change), 32'h1);
    check("sw_zero", io_sw, 32'h0);
    ticks(4);
    check("btn3_lvl", 32'(io_btn), 32'h8);

    // Reset while button 0 is mid-debounce and button 3 is held.
    sw_raw  = 32'h12345678;
    btn_raw = 4'b0110;
    ticks(4);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_btn", 32'(io_btn), 32'h0);
    check("mid_rst_sw", io_sw, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    ticks(2);
    check("rst_sw_back", io_sw, 32'h12345678);
    ticks(4);
    check("rst_e6", 32'(io_btn), 32'h0);
    tick();
    check("rst_e7_lvl", 32'(io_btn), 32'h9);
    check("rst_e7_press", 32'(btn_press), 32'h9);

`ifdef IO_BTN_STICKY_EN
    tick();
    check("sticky_set", 32'(btn_sticky[0]), 32'h1);
    btn_raw = 4'b0111;
    ticks(10);
    check("sticky_hold_lvl", 32'(io_btn[0]), 32'h0);
    check("sticky_hold", 32'(btn_sticky[0]), 32'h1);
    btn_clr = 4'b0001;
    tick();
    btn_clr = 4'b0000;
    check("sticky_clr", 32'(btn_sticky[0]), 32'h0);
    btn_raw = 4'b0110;
    ticks(7);
    check("sticky_press2", 32'(btn_press[0]), 32'h1);
    btn_clr = 4'b0001;
    tick();
    btn_clr = 4'b0000;
    check("sticky_set_wins", 32'(btn_sticky[0]), 32'h1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
